req_debounce_arb_4: RTL and testbench
=====================================

Name: req_debounce_arb_4

Overview:
- Upstream stage for the 4-to-2 encoder.
- Takes four raw, asynchronous, possibly bouncy request lines and synchronises and debounces each one.
- Each debounced rising edge is latched as a sticky pending request.
- The highest-priority pending request is presented as a one-hot 4-bit vector (directly encodable) under a valid/ack handshake.

Parameters:
- DB_CYCLES, 4, consecutive post-synchroniser cycles a new level must hold before it is accepted; legal range 1..2**CNT_W-1.
- CNT_W, 3, width of each per-channel debounce counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  4  raw request lines; bit 3 has the highest priority.
- d_out  output  4  one-hot presented request; 4'b0000 when valid=0.
- valid  output  1  d_out holds a request.
- ack  input  1  consumer accepted d_out; ignored when valid=0.
- drop_cnt  output  8  lost-event counter (see Optional Feature).

Behaviour:
- Clock/reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values, all 0: sync1, sync2, stable, cnt[i], pending, d_out, valid, drop_cnt. State is IDLE.
- Reset mid-handshake: everything clears on that edge and the request is lost.
- Synchroniser: 2 flops per channel, d_in -> sync1 -> sync2.
- Debounce, per channel i:
  - If sync2[i]==stable[i]: cnt[i]<=0.
  - Else if cnt[i]==DB_CYCLES-1: stable[i]<=sync2[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - Any glitch that returns to the stable level before acceptance resets the count.
- Pending: a rising edge of stable[i] (stable now 1, previous 0) sets pending[i] on the next edge. Falling edges are ignored. pending is sticky until acked.
- Arbiter FSM, two states:
  - IDLE: if pending!=0, load d_out with the one-hot of the highest set index, valid<=1, go to PRESENT. Otherwise hold d_out=0, valid=0.
  - PRESENT: d_out and valid hold constant. When ack=1: clear pending[sel], d_out<=0, valid<=0, go to IDLE.
  - valid is therefore low for at least 1 cycle between consecutive requests.
- Simultaneous events:
  - Set vs clear of the same pending bit in the same cycle (ack plus a new rising edge on sel): set wins, so the request is re-presented after the IDLE cycle.
  - A higher-priority request arriving during PRESENT does not pre-empt; it is served next.
  - Multiple channels pending: served strictly 3>2>1>0 on each IDLE visit. Lower channels may starve; this is intended.
- Latency: a raw level change that is stable from the edge first sampling it (edge 1) gives:
  - stable updates at edge DB_CYCLES+2;
  - pending sets at edge DB_CYCLES+3;
  - valid asserts at edge DB_CYCLES+4 (edge 8 for the default).
- Ack-to-valid-low: 1 edge.

Optional Feature:
- Macro: REQ_DROP_CNT_EN.
- Defined: drop_cnt increments by 1 on every debounced rising edge of channel i while pending[i] is already 1 and is not being cleared that cycle.
  - Edges on multiple channels in one cycle count once per channel; a 2-channel drop adds 2.
  - The counter saturates at 8'hFF and clears only on rst.
- Not defined: the counter logic is absent and drop_cnt is tied to 8'h00.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with d_in=4'b1111, then rst=0 with d_in=0 -> d_out=0, valid=0, drop_cnt=0 throughout.
- Debounce latency: d_in[1] rises and stays high -> valid=1, d_out=4'b0010 exactly at edge 8 (DB_CYCLES=4). Ack for 1 cycle -> valid=0, d_out=0 on the next edge.
- Glitch rejection: d_in[2] high for 3 cycles, low for 1, high for 3, then low -> valid never asserts and pending stays 0.
- Priority: d_in=4'b0101 rises together, ack held low -> d_out=4'b0100. Ack 1 cycle -> 1 IDLE cycle with valid=0, then d_out=4'b0001.
- Set/clear collision: re-trigger channel 3 so its debounced edge lands in the same cycle as ack of 4'b1000 -> after 1 IDLE cycle d_out=4'b1000 and valid=1 again.
- REQ_DROP_CNT_EN: hold ack=0 while pulsing debounced edges on channel 0 three times -> drop_cnt=2; without the macro, drop_cnt=0.

Source files
------------

// File: rtl/req_debounce_arb_4.sv
// Four-channel request front end: 2-flop synchroniser, per-channel debounce, sticky pending
// latch and a fixed-priority (3>2>1>0) one-hot presenter with a valid/ack handshake.
// Optional lost-event counter enabled by defining REQ_DROP_CNT_EN.
module req_debounce_arb_4 #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_in,
    output logic [3:0] d_out,
    output logic       valid,
    input  logic       ack,
    output logic [7:0] drop_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [3:0]       stable_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       pending_q;
    logic [3:0]       pending_d;
    logic [3:0]       rise;
    logic [3:0]       clr;
    logic [3:0]       d_out_q;
    logic [3:0]       d_out_d;
    logic             valid_q;
    logic             valid_d;
    state_t           state_q;
    state_t           state_d;

    function automatic logic [3:0] top_onehot(input logic [3:0] req);
        logic [3:0] oh;
        oh = 4'b0000;
        if (req[3])      oh = 4'b1000;
        else if (req[2]) oh = 4'b0100;
        else if (req[1]) oh = 4'b0010;
        else if (req[0]) oh = 4'b0001;
        return oh;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
        end
    end

    // A differing level must survive DB_CYCLES consecutive samples; any return resets the count.
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
        assign stable_d[gi] = ((sync2_q[gi] != stable_q[gi]) && (cnt_q[gi] == DB_LAST))
                              ? sync2_q[gi] : stable_q[gi];
        assign cnt_d[gi]    = ((sync2_q[gi] == stable_q[gi]) || (cnt_q[gi] == DB_LAST))
                              ? '0 : cnt_q[gi] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q      <= 4'b0000;
            stable_prev_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise = stable_q & ~stable_prev_q;

    // A new rising edge outranks the ack clear of the same bit, so the request is re-presented.
    assign pending_d = (pending_q & ~clr) | rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 4'b0000;
            d_out_q   <= 4'b0000;
            valid_q   <= 1'b0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            d_out_q   <= d_out_d;
            valid_q   <= valid_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        d_out_d = d_out_q;
        valid_d = valid_q;
        clr     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (pending_q != 4'b0000) begin
                    d_out_d = top_onehot(pending_q);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end else begin
                    d_out_d = 4'b0000;
                    valid_d = 1'b0;
                end
            end
            PRESENT: begin
                if (ack) begin
                    clr     = d_out_q;
                    d_out_d = 4'b0000;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                d_out_d = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    assign d_out = d_out_q;
    assign valid = valid_q;

`ifdef REQ_DROP_CNT_EN
    logic [7:0] drop_q;
    logic [7:0] drop_d;
    logic [3:0] drop_ev;
    logic [2:0] drop_inc;
    logic [8:0] drop_sum;

    // An edge is lost when its pending bit is already set and survives this cycle.
    assign drop_ev  = rise & pending_q & ~clr;
    assign drop_inc = 3'(drop_ev[0]) + 3'(drop_ev[1]) + 3'(drop_ev[2]) + 3'(drop_ev[3]);
    assign drop_sum = {1'b0, drop_q} + 9'(drop_inc);
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 8'h00;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_req_debounce_arb_4.sv
// Self-checking bench for req_debounce_arb_4: directed scenarios plus a randomized run,
// all checked against an event-level reference model of the request front end.
module tb_req_debounce_arb_4;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d_in;
    logic [3:0] d_out;
    logic       valid;
    logic       ack;
    logic [7:0] drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    req_debounce_arb_4 #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .d_out    (d_out),
        .valid    (valid),
        .ack      (ack),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples reach the debouncer two edges late; a level is accepted once
    // the last DB samples all disagree with the accepted level; an accepted rise becomes a pending
    // request one edge later; requests are served by channel index, highest first.
    logic [3:0] m_pipe[$] = '{4'b0000, 4'b0000};
    logic [3:0] m_win[$];
    logic [3:0] m_stable    = 4'b0000;
    logic [3:0] m_rise_prev = 4'b0000;
    logic [3:0] m_pending   = 4'b0000;
    int         m_sel       = -1;
    int         m_drop      = 0;

    task automatic model_edge();
        logic [3:0] s2;
        logic [3:0] new_stable;
        logic [3:0] clear_mask;
        int         new_sel;
        bit         all_diff;
        if (rst) begin
            m_pipe      = '{4'b0000, 4'b0000};
            m_win.delete();
            m_stable    = 4'b0000;
            m_rise_prev = 4'b0000;
            m_pending   = 4'b0000;
            m_sel       = -1;
            m_drop      = 0;
            return;
        end
        clear_mask = 4'b0000;
        new_sel    = m_sel;
        if (m_sel >= 0) begin
            if (ack) begin
                clear_mask[m_sel] = 1'b1;
                new_sel = -1;
            end
        end else if (m_pending != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pending[i]) new_sel = i;
            end
        end
`ifdef REQ_DROP_CNT_EN
        for (int i = 0; i < 4; i++) begin
            if (m_rise_prev[i] && m_pending[i] && !clear_mask[i] && m_drop < 255) m_drop++;
        end
`endif
        m_pending = (m_pending & ~clear_mask) | m_rise_prev;
        s2 = m_pipe.pop_front();
        m_pipe.push_back(d_in);
        m_win.push_back(s2);
        while (m_win.size() > DB) void'(m_win.pop_front());
        new_stable = m_stable;
        if (m_win.size() == DB) begin
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                foreach (m_win[k]) begin
                    if (m_win[k][i] == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) new_stable[i] = ~m_stable[i];
            end
        end
        m_rise_prev = new_stable & ~m_stable;
        m_stable    = new_stable;
        m_sel       = new_sel;
    endtask

    function automatic logic [3:0] exp_dout();
        logic [3:0] one;
        one = 4'b0001;
        return (m_sel >= 0) ? (one << m_sel) : 4'b0000;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        d_in = 4'b1111;
        ack  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests_run++;
            if (d_out !== 4'b0000 || valid !== 1'b0 || drop_cnt !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_hold cyc=%0d d_out=%b valid=%b drop=%0d required 0000/0/0",
                         c, d_out, valid, drop_cnt);
            end
        end
        rst  = 1'b0;
        d_in = 4'b0000;
        for (int c = 0; c < 12; c++) begin
            step();
            tests_run++;
            if (d_out !== 4'b0000 || valid !== 1'b0 || drop_cnt !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_idle cyc=%0d d_out=%b valid=%b drop=%0d required 0000/0/0",
                         c, d_out, valid, drop_cnt);
            end
        end
        $display("[TB] reset scenario done");
    endtask

    task automatic test_latency();
        d_in = 4'b0010;
        for (int e = 1; e <= DB + 4; e++) begin
            step();
            tests_run++;
            if (e < DB + 4) begin
                if (valid !== 1'b0 || valid !== (m_sel >= 0)) begin
                    tests_failed++;
                    $display("FAIL latency_early edge=%0d valid=%b required 0", e, valid);
                end
            end else begin
                if (valid !== 1'b1 || d_out !== 4'b0010 || d_out !== exp_dout()) begin
                    tests_failed++;
                    $display("FAIL latency_valid edge=%0d valid=%b d_out=%b required 1/0010",
                             e, valid, d_out);
                end
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || d_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL latency_ack valid=%b d_out=%b required 0/0000", valid, d_out);
        end
        d_in = 4'b0000;
        for (int c = 0; c < 12; c++) begin
            step();
            tests_run++;
            if (valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL latency_fall cyc=%0d valid=%b required 0", c, valid);
            end
        end
        $display("[TB] latency: ch1 presented at edge %0d and acked", DB + 4);
    endtask

    task automatic test_glitch();
        logic pat[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 24; c++) begin
            d_in[2] = (c < 7) ? pat[c] : 1'b0;
            step();
            tests_run++;
            if (valid !== 1'b0 || m_pending !== 4'b0000 || d_out !== 4'b0000) begin
                tests_failed++;
                $display("FAIL glitch cyc=%0d valid=%b d_out=%b model_pending=%b required 0/0000/0000",
                         c, valid, d_out, m_pending);
            end
        end
        $display("[TB] glitch on ch2 rejected");
    endtask

    task automatic test_priority();
        int n;
        d_in = 4'b0101;
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (valid !== 1'b1 || d_out !== 4'b0100 || d_out !== exp_dout()) begin
            tests_failed++;
            $display("FAIL priority_first valid=%b d_out=%b required 1/0100", valid, d_out);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || d_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL priority_gap valid=%b d_out=%b required 0/0000", valid, d_out);
        end
        step();
        tests_run++;
        if (valid !== 1'b1 || d_out !== 4'b0001 || d_out !== exp_dout()) begin
            tests_failed++;
            $display("FAIL priority_second valid=%b d_out=%b required 1/0001", valid, d_out);
        end
        ack = 1'b1;
        step();
        ack  = 1'b0;
        d_in = 4'b0000;
        repeat (12) step();
        tests_run++;
        if (valid !== 1'b0 || valid !== (m_sel >= 0)) begin
            tests_failed++;
            $display("FAIL priority_drain valid=%b required 0", valid);
        end
        $display("[TB] priority: ch2 then ch0 served");
    endtask

    task automatic test_collision();
        int n;
        d_in = 4'b1000;
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (valid !== 1'b1 || d_out !== 4'b1000) begin
            tests_failed++;
            $display("FAIL collision_first valid=%b d_out=%b required 1/1000", valid, d_out);
        end
        d_in = 4'b0000;
        repeat (10) step();
        d_in = 4'b1000;
        repeat (DB + 2) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || valid !== (m_sel >= 0)) begin
            tests_failed++;
            $display("FAIL collision_gap valid=%b required 0", valid);
        end
        step();
        tests_run++;
        if (valid !== 1'b1 || d_out !== 4'b1000 || drop_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL collision_repeat valid=%b d_out=%b drop=%0d required 1/1000/0",
                     valid, d_out, drop_cnt);
        end
        ack = 1'b1;
        step();
        ack  = 1'b0;
        d_in = 4'b0000;
        repeat (12) step();
        $display("[TB] collision: ch3 re-presented after ack");
    endtask

    task automatic test_drop_cnt();
        logic [7:0] want;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ack = 1'b0;
        for (int p = 0; p < 3; p++) begin
            d_in = 4'b0001;
            repeat (8) step();
            d_in = 4'b0000;
            repeat (8) step();
        end
`ifdef REQ_DROP_CNT_EN
        want = 8'd2;
`else
        want = 8'd0;
`endif
        tests_run++;
        if (drop_cnt !== want || drop_cnt !== 8'(m_drop) || valid !== 1'b1 || d_out !== 4'b0001) begin
            tests_failed++;
            $display("FAIL drop_cnt drop=%0d valid=%b d_out=%b required %0d/1/0001",
                     drop_cnt, valid, d_out, want);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (4) step();
        $display("[TB] drop counter reads %0d after three ch0 edges", drop_cnt);
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 99) < 5) d_in[b] = ~d_in[b];
            end
            ack = ($urandom_range(0, 3) == 0);
            if (ack && valid === 1'b1) $display("[TB] rand cyc=%0d ack d_out=%b", c, d_out);
            step();
            tests_run++;
            if (d_out !== exp_dout() || valid !== (m_sel >= 0) || drop_cnt !== 8'(m_drop)) begin
                tests_failed++;
                errs++;
                if (errs <= 20)
                    $display("FAIL random cyc=%0d d_out=%b valid=%b drop=%0d required %b/%0b/%0d",
                             c, d_out, valid, drop_cnt, exp_dout(), (m_sel >= 0), m_drop);
            end
        end
        ack  = 1'b0;
        d_in = 4'b0000;
        $display("[TB] random run finished, model drop count %0d", m_drop);
    endtask

    initial begin
        rst  = 1'b1;
        d_in = 4'b0000;
        ack  = 1'b0;
        test_reset();
        test_latency();
        test_glitch();
        test_priority();
        test_collision();
        test_drop_cnt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout simulation exceeded 1ms");
        $fatal(1, "timeout");
    end

endmodule
